// File: rtl/vga_fb_scanout.sv
// 640x480@60 VGA scanout of a 40x30 one-bit cell framebuffer.
// The bitmap is snapshotted on entry to vertical blanking, so writes made mid-frame never tear.
module vga_fb_scanout #(
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter int          CELL_SHIFT = 4,
    parameter int          FB_COLS    = 40,
    parameter int          FB_ROWS    = 30,
    // Raster geometry in pixel ticks; the defaults give standard 640x480@60.
    parameter int          H_VISIBLE  = 640,
    parameter int          H_FRONT    = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          V_VISIBLE  = 480,
    parameter int          V_FRONT    = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_button,
    input  logic [FB_COLS*FB_ROWS-1:0]   framebuffer,
    output logic [3:0]                   red_out,
    output logic [3:0]                   green_out,
    output logic [3:0]                   blue_out,
    output logic                         h_sync_out,
    output logic                         v_sync_out,
    output logic                         frame_done
);

    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_LOAD       = 10'(V_VISIBLE - 1);

    function automatic logic [11:0] pixel_color(input logic cell_bit, input logic vld);
        if (!vld)
            return 12'h000;
        return cell_bit ? FG_COLOR : BG_COLOR;
    endfunction

    logic                       phase;
    logic                       pix_tick;
    logic [9:0]                 h_count;
    logic [9:0]                 v_count;
    logic [FB_COLS*FB_ROWS-1:0] snapshot;

    logic [9:0]  col_p0;
    logic [9:0]  row_p0;
    logic [10:0] row_x_p0;
    logic [10:0] idx_p0;
    logic        vld_p0;
    logic        cell_p0;
    logic        h_sync_p0;
    logic        v_sync_p0;

    logic [11:0] rgb_p1;
    logic        h_sync_p1;
    logic        v_sync_p1;
    logic        frame_done_p1;

    // Tick is high on the first clock after reset release, then every other clock.
    assign pix_tick = ~phase;

    // Stage p0: decode the current raster position into cell index and sync levels.
    assign col_p0    = h_count >> CELL_SHIFT;
    assign row_p0    = v_count >> CELL_SHIFT;
    assign row_x_p0  = {1'b0, row_p0};
    assign idx_p0    = (row_x_p0 << 5) + (row_x_p0 << 3) + {1'b0, col_p0};
    assign vld_p0    = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    assign cell_p0   = vld_p0 ? snapshot[idx_p0] : 1'b0;
    assign h_sync_p0 = !((h_count >= H_SYNC_START) && (h_count < H_SYNC_END));
    assign v_sync_p0 = !((v_count >= V_SYNC_START) && (v_count < V_SYNC_END));

    always_ff @(posedge CLOCK_50) begin
        if (!reset_button) begin
            phase         <= 1'b0;
            h_count       <= '0;
            v_count       <= '0;
            snapshot      <= '0;
            rgb_p1        <= '0;
            h_sync_p1     <= 1'b1;
            v_sync_p1     <= 1'b1;
            frame_done_p1 <= 1'b0;
        end else begin
            phase         <= ~phase;
            frame_done_p1 <= 1'b0;
            // Stage p1: every output is registered from the same p0 decode, so they never skew.
            rgb_p1        <= pixel_color(cell_p0, vld_p0);
            h_sync_p1     <= h_sync_p0;
            v_sync_p1     <= v_sync_p0;
            if (pix_tick) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
                    if (v_count == V_LOAD) begin
                        snapshot      <= framebuffer;
                        frame_done_p1 <= 1'b1;
                    end
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    assign red_out    = rgb_p1[11:8];
    assign green_out  = rgb_p1[7:4];
    assign blue_out   = rgb_p1[3:0];
    assign h_sync_out = h_sync_p1;
    assign v_sync_out = v_sync_p1;
    assign frame_done = frame_done_p1;

endmodule
